// File: rtl/seg_scan_mux.sv
// seg_scan_mux: time-multiplexes the tens/ones 7-segment patterns onto one shared
// segment bus with per-digit common enables; hundreds != 0 is shown on the ones-slot dp.
// Ports: clk, rst (async, active-high); seg_tens/seg_ones/hund in; seg_out/dp/dig_en pins out.
// Optional macro LEADING_ZERO_BLANK_EN: blanks a leading tens zero when hundreds is zero.
module seg_scan_mux #(
    parameter int REFRESH_DIV    = 50000,
    parameter int BLANK_CYCLES   = 2,
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] seg_tens,
    input  logic [6:0] seg_ones,
    input  logic [1:0] hund,
    output logic [6:0] seg_out,
    output logic       dp,
    output logic [1:0] dig_en
);

    localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam bit HAS_BLANK = (BLANK_CYCLES > 0);
    localparam logic [CNT_W-1:0] DIG_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        S_BLANK_T = 2'd0,
        S_TENS    = 2'd1,
        S_BLANK_O = 2'd2,
        S_ONES    = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [6:0]       snap_tens;
    logic [6:0]       snap_ones;
    logic [1:0]       snap_hund;
    logic [6:0]       snap_tens_nxt;
    logic [6:0]       snap_ones_nxt;
    logic [1:0]       snap_hund_nxt;
    logic             capture;

    // Logical (active-high) output registers and their next values.
    logic [6:0] seg_l;
    logic       dp_l;
    logic [1:0] en_l;
    logic [6:0] seg_l_nxt;
    logic       dp_l_nxt;
    logic [1:0] en_l_nxt;

    // Next-state: with no blank cycles the blank states are left on the first edge,
    // which is how the post-reset S_BLANK_T collapses straight into S_TENS.
    always_comb begin
        state_nxt = S_BLANK_T;
        case (state)
            S_BLANK_T: state_nxt = (!HAS_BLANK || cnt == BLK_LAST) ? S_TENS : S_BLANK_T;
            S_TENS:    state_nxt = (cnt == DIG_LAST) ? (HAS_BLANK ? S_BLANK_O : S_ONES) : S_TENS;
            S_BLANK_O: state_nxt = (!HAS_BLANK || cnt == BLK_LAST) ? S_ONES : S_BLANK_O;
            S_ONES:    state_nxt = (cnt == DIG_LAST) ? (HAS_BLANK ? S_BLANK_T : S_TENS) : S_ONES;
            default:   state_nxt = S_BLANK_T;
        endcase
    end

    // The frame is frozen on the edge that enters the tens slot; outputs are decoded
    // from the post-edge snapshot so the captured value shows on that same edge.
    always_comb begin
        capture       = (state_nxt == S_TENS) && (state != S_TENS);
        snap_tens_nxt = capture ? seg_tens : snap_tens;
        snap_ones_nxt = capture ? seg_ones : snap_ones;
        snap_hund_nxt = capture ? hund     : snap_hund;
    end

    always_comb begin
        seg_l_nxt = 7'b0;
        dp_l_nxt  = 1'b0;
        en_l_nxt  = 2'b00;
        case (state_nxt)
            S_TENS: begin
                seg_l_nxt = snap_tens_nxt;
                en_l_nxt  = 2'b10;
`ifdef LEADING_ZERO_BLANK_EN
                if (snap_tens_nxt == 7'b1111110 && snap_hund_nxt == 2'd0) begin
                    seg_l_nxt = 7'b0;
                    en_l_nxt  = 2'b00;
                end
`endif
            end
            S_ONES: begin
                seg_l_nxt = snap_ones_nxt;
                dp_l_nxt  = (snap_hund_nxt != 2'd0);
                en_l_nxt  = 2'b01;
            end
            default: begin
                seg_l_nxt = 7'b0;
                dp_l_nxt  = 1'b0;
                en_l_nxt  = 2'b00;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_BLANK_T;
            cnt       <= '0;
            snap_tens <= 7'b0;
            snap_ones <= 7'b0;
            snap_hund <= 2'b0;
            seg_l     <= 7'b0;
            dp_l      <= 1'b0;
            en_l      <= 2'b00;
        end else begin
            state     <= state_nxt;
            cnt       <= (state_nxt != state) ? '0 : cnt + CNT_W'(1);
            snap_tens <= snap_tens_nxt;
            snap_ones <= snap_ones_nxt;
            snap_hund <= snap_hund_nxt;
            seg_l     <= seg_l_nxt;
            dp_l      <= dp_l_nxt;
            en_l      <= en_l_nxt;
        end
    end

    // Pin polarity; reset forces logical zeros, so active-low pins go high asynchronously.
    assign seg_out = seg_l ^ {7{SEG_ACTIVE_LOW}};
    assign dp      = dp_l ^ SEG_ACTIVE_LOW;
    assign dig_en  = en_l ^ {2{SEG_ACTIVE_LOW}};

endmodule

// File: tb/tb_seg_scan_mux.sv
// tb_seg_scan_mux: randomized and directed stimulus on two seg_scan_mux instances
// (R=4,B=1,active-high and R=3,B=0,active-low) against a slot-position reference model.
// Prints one summary line with the comparison and error counts.
module tb_seg_scan_mux;

    logic       clk = 1'b0;
    logic       rst1;
    logic       rst2;
    logic [6:0] seg_tens;
    logic [6:0] seg_ones;
    logic [1:0] hund;
    logic [6:0] seg_out1, seg_out2;
    logic       dp1, dp2;
    logic [1:0] dig_en1, dig_en2;

    int n_checks = 0;
    int n_errors = 0;

    // Model state per instance: edges since reset release, and the frame snapshot.
    int         k  [2];
    logic [6:0] m_t[2];
    logic [6:0] m_o[2];
    logic [1:0] m_h[2];

    localparam int R1 = 4, B1 = 1;
    localparam int R2 = 3, B2 = 0;

    always #5 clk = ~clk;

    seg_scan_mux #(.REFRESH_DIV(R1), .BLANK_CYCLES(B1), .SEG_ACTIVE_LOW(1'b0)) dut1 (
        .clk(clk), .rst(rst1), .seg_tens(seg_tens), .seg_ones(seg_ones), .hund(hund),
        .seg_out(seg_out1), .dp(dp1), .dig_en(dig_en1)
    );

    seg_scan_mux #(.REFRESH_DIV(R2), .BLANK_CYCLES(B2), .SEG_ACTIVE_LOW(1'b1)) dut2 (
        .clk(clk), .rst(rst2), .seg_tens(seg_tens), .seg_ones(seg_ones), .hund(hund),
        .seg_out(seg_out2), .dp(dp2), .dig_en(dig_en2)
    );

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Position inside the frame after kk edges: frame laid out as
    // [blank B][tens R][blank B][ones R]; with B=0 the first edge lands on tens.
    function automatic int frame_pos(int R, int B, int kk);
        int p_len;
        p_len = 2 * (B + R);
        return (B > 0) ? (kk % p_len) : ((kk - 1) % p_len);
    endfunction

    function automatic logic [9:0] expect_pins(int R, int B, bit al, int kk,
                                               logic [6:0] t, logic [6:0] o,
                                               logic [1:0] h, logic in_rst);
        logic [6:0] s;
        logic       d;
        logic [1:0] e;
        int         p;
        s = 7'b0;
        d = 1'b0;
        e = 2'b00;
        if (!in_rst && !(B == 0 && kk == 0)) begin
            p = frame_pos(R, B, kk);
            if (p >= B && p < B + R) begin
                s = t;
                e = 2'b10;
`ifdef LEADING_ZERO_BLANK_EN
                if (t == 7'b1111110 && h == 2'd0) begin
                    s = 7'b0;
                    e = 2'b00;
                end
`endif
            end else if (p >= 2 * B + R) begin
                s = o;
                d = (h != 2'd0);
                e = 2'b01;
            end
        end
        return al ? ~{s, d, e} : {s, d, e};
    endfunction

    task automatic model_edge(input int id, input int R, input int B, input logic r);
        if (r) begin
            k[id]   = 0;
            m_t[id] = 7'b0;
            m_o[id] = 7'b0;
            m_h[id] = 2'b0;
        end else begin
            k[id]++;
            if (frame_pos(R, B, k[id]) == B) begin
                m_t[id] = seg_tens;
                m_o[id] = seg_ones;
                m_h[id] = hund;
            end
        end
    endtask

    task automatic check_all();
        chk_eq("dut1_pins", {22'b0, seg_out1, dp1, dig_en1},
               {22'b0, expect_pins(R1, B1, 1'b0, k[0], m_t[0], m_o[0], m_h[0], rst1)});
        chk_eq("dut1_en_not_11", {31'b0, dig_en1 == 2'b11}, 32'd0);
        chk_eq("dut2_pins", {22'b0, seg_out2, dp2, dig_en2},
               {22'b0, expect_pins(R2, B2, 1'b1, k[1], m_t[1], m_o[1], m_h[1], rst2)});
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge(0, R1, B1, rst1);
        model_edge(1, R2, B2, rst2);
        #1;
        check_all();
    endtask

    initial begin
        rst1     = 1'b1;
        rst2     = 1'b1;
        seg_tens = 7'b0;
        seg_ones = 7'b0;
        hund     = 2'b0;
        for (int i = 0; i < 2; i++) begin
            k[i] = 0; m_t[i] = 7'b0; m_o[i] = 7'b0; m_h[i] = 2'b0;
        end
        #1;
        check_all();
        repeat (3) tick();

        // Value 42 from the first frame after release.
        rst1     = 1'b0;
        seg_tens = 7'b0110011;
        seg_ones = 7'b1101101;
        hund     = 2'd0;
        repeat (20) tick();

        // Change ones in the second cycle of the tens slot.
        for (int i = 0; i < 20; i++) begin
            if (frame_pos(R1, B1, k[0]) == B1 + 1) break;
            tick();
        end
        chk_eq("tens_slot_cycle2", {30'b0, dig_en1}, 32'd2);
        seg_ones = 7'b1111111;
        repeat (20) tick();

        // Overflow on dp, then leading zero with and without hundreds.
        hund     = 2'd1;
        seg_tens = 7'b1111110;
        seg_ones = 7'b1011011;
        repeat (20) tick();
        hund     = 2'd0;
        seg_ones = 7'b0000111;
        repeat (20) tick();

        // Random inputs every cycle with occasional asynchronous mid-slot resets.
        for (int i = 0; i < 400; i++) begin
            seg_tens = ($urandom_range(0, 3) == 0) ? 7'b1111110 : 7'($urandom);
            seg_ones = 7'($urandom);
            hund     = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 49) == 0) begin
                #2;
                rst1 = 1'b1;
                #1;
                check_all();
                tick();
                rst1 = 1'b0;
            end
            tick();
        end

        // Active-low instance without blanking: first edge enables tens.
        seg_tens = 7'b0110000;
        seg_ones = 7'b1011011;
        hund     = 2'd2;
        chk_eq("dut2_idle_pins", {22'b0, seg_out2, dp2, dig_en2}, 32'h3FF);
        rst2 = 1'b0;
        tick();
        chk_eq("dut2_first_en", {30'b0, dig_en2}, 32'd1);
        repeat (4) tick();
        chk_eq("dut2_in_ones", {30'b0, dig_en2}, 32'd2);
        #2;
        rst2 = 1'b1;
        #1;
        chk_eq("dut2_async_rst", {22'b0, seg_out2, dp2, dig_en2}, 32'h3FF);
        check_all();
        tick();
        rst2 = 1'b0;
        for (int i = 0; i < 40; i++) begin
            seg_tens = ($urandom_range(0, 2) == 0) ? 7'b1111110 : 7'($urandom);
            seg_ones = 7'($urandom);
            hund     = 2'($urandom_range(0, 3));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
